remote_comm: RTL and testbench
==============================

# remote_comm

Host-side command bridge for the knight-robot system, used by the bench to drive the robot over UART. A 16-bit command is presented on `cmd` and `snd_cmd` is pulsed. The block then serializes the command as two UART bytes, high byte first, and pulses `cmd_snt` when the second byte has fully left. Independently and full-duplex, it receives single response bytes from the robot (for example the positive acknowledge `0xA5`) and presents them on `resp` with `resp_rdy`.

## Interface
- `BAUD_DIV`, default 2604: clocks per UART bit (19200 baud at 50 MHz).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `RX` in 1: serial input from the robot's TX; asynchronous to `clk`.
- `TX` out 1: serial output to the robot's RX; idles high.
- `cmd` in 16: command word, sampled only when `snd_cmd` is accepted.
- `snd_cmd` in 1: one-cycle request to send `cmd`.
- `cmd_snt` out 1: one-cycle pulse when both bytes have been transmitted.
- `resp_rdy` out 1: a received byte is valid on `resp`.
- `resp` out 8: last correctly received byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). No parity.
- Send FSM has states IDLE → HIGH → LOW → DONE → IDLE.
  - **IDLE:** a `snd_cmd` high at a clock edge latches `cmd` into a 16-bit register and moves to HIGH.
  - **HIGH:** transmits `cmd[15:8]`. At the end of its stop bit, moves to LOW.
  - **LOW:** transmits `cmd[7:0]`. At the end of its stop bit, moves to DONE.
  - **DONE:** asserts `cmd_snt` for exactly one cycle, then returns to IDLE.
  - Accepting a new `snd_cmd` from DONE happens only on the following cycle, i.e. after the FSM is back in IDLE.
- `snd_cmd` in any state other than IDLE is ignored. The latched command is never overwritten mid-send.
- Receiver:
  - `RX` is double-flopped before use.
  - A falling edge starts a frame; bits are sampled at mid-bit, `BAUD_DIV/2` after the start edge and every `BAUD_DIV` thereafter.
  - After the stop-bit sample, if the stop bit is 1: load `resp` and set `resp_rdy`.
  - If the stop bit is 0 (framing error): discard the byte and leave `resp` and `resp_rdy` unchanged.
- `resp_rdy` is a level: it stays high until the next detected start edge or reset.
- The transmitter and receiver operate concurrently with no interlock.

## Timing
- Reset values: `TX`=1, `cmd_snt`=0, `resp_rdy`=0, `resp`=`0x00`, send FSM in IDLE, RX FSM idle.
- Reset asserted mid-frame forces `TX` high immediately (asynchronously) and abandons the frame. No `cmd_snt` is produced for the abandoned command.
- `TX` drives the start bit of the high byte on the cycle after `snd_cmd` is accepted.
- Each bit lasts exactly `BAUD_DIV` clocks.
- The low byte's start bit immediately follows the high byte's stop bit, with no extra idle.
- `cmd_snt` is high exactly 20·`BAUD_DIV`+1 cycles after the accept edge. `TX` is high (idle) from then on.
- `resp`/`resp_rdy` update on the cycle after the stop-bit sample. Start-edge to `resp_rdy` is about 9.5·`BAUD_DIV` plus 2–3 cycles of synchronizer latency.
- Baud counters are wide enough for `BAUD_DIV` up to 65535. Counters reset to 0 at each bit boundary.

## Structure
- Shared package `knight_pkg`:
  - `BAUD_DIV` default.
  - Response codes `POS_ACK`=`0xA5` and `DONE`=`0x5A`.
  - Command opcode constants, e.g. `CAL_GYRO` and `TOUR`=`4'h7`.
- Sub-module `uart`:
  - TX side: `trmt`, `tx_data`, `tx_done`, `TX`.
  - RX side: `RX`, `rx_data`, `rdy`.
- `remote_comm` holds only the send FSM and the command latch around `uart`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-byte → `TX`=1, `cmd_snt`=0, `resp_rdy`=0 immediately. After release, no stray frame appears.
- **Send `0x7004`:**
  - `TX` shows start, 0,0,0,0,1,1,1,0, stop, then start, 0,0,1,0,0,0,0,0, stop.
  - Each bit is `BAUD_DIV` clocks.
  - `cmd_snt` pulses once, 20·`BAUD_DIV`+1 cycles after `snd_cmd`.
- **Busy:** pulse `snd_cmd` with `cmd`=`0xFFFF` during the high byte of `0x7004` → the transmitted bytes are still `0x70`, `0x04`, and there is only one `cmd_snt`.
- **Loopback:**
  - Tie `TX` to `RX` and send `0xA55A` → `resp`=`0xA5`, then `0x5A`.
  - `resp_rdy` drops at the second start edge and reasserts after the second byte.
- **Framing error:** drive `RX` with data `0x3C` and stop bit 0 → `resp`/`resp_rdy` unchanged. A following valid `0xA5` frame is received correctly.
- **Back-to-back:** issue `snd_cmd` on the first cycle after `cmd_snt` (FSM back in IDLE) → the second command starts with no lost cycles. Both commands complete with one `cmd_snt` each.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared constants for the knight-robot host bridge: baud default, response
// codes, command opcodes and the send-FSM state type.
package knight_pkg;

  localparam int unsigned BAUD_DIV_DFLT = 2604;
  localparam int unsigned CNT_W         = 16;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] DONE    = 8'h5A;

  localparam logic [3:0] CAL_GYRO = 4'h2;
  localparam logic [3:0] TOUR     = 4'h7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } send_state_t;

endpackage

// File: rtl/uart.sv
// Full-duplex 8N1 UART: one transmitter and one receiver sharing BAUD_DIV.
// tx_done is combinational so a follow-on byte can start with no idle gap.
module uart
  import knight_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);

  logic [9:0]       tx_shft;
  logic [CNT_W-1:0] tx_baud;
  logic [3:0]       tx_bits;
  logic             tx_busy;
  logic             tx_bit_end;

  assign tx_bit_end = tx_busy && (tx_baud == FULL_CNT);
  assign tx_done    = tx_bit_end && (tx_bits == 4'd9);
  assign TX         = tx_shft[0];

  // Transmit shifter; idle ones refill from the top so TX rests high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_baud <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
    end else if (trmt) begin
      tx_shft <= {1'b1, tx_data, 1'b0};
      tx_baud <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_bit_end) begin
        tx_shft <= {1'b1, tx_shft[9:1]};
        tx_baud <= '0;
        if (tx_bits == 4'd9) begin
          tx_bits <= '0;
          tx_busy <= 1'b0;
        end else begin
          tx_bits <= tx_bits + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + CNT_W'(1);
      end
    end
  end

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_baud;
  logic [3:0]       rx_bits;
  logic [7:0]       rx_shft;
  logic [CNT_W-1:0] rx_target;
  logic             rx_sample;

  assign rx_target = (rx_bits == 4'd0) ? HALF_CNT : FULL_CNT;
  assign rx_sample = rx_busy && (rx_baud == rx_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive: start on falling edge, sample mid-bit, accept only a high stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_baud <= '0;
      rx_bits <= '0;
      rx_shft <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
    end else if (!rx_busy) begin
      if (rx_prev && !rx_sync) begin
        rx_busy <= 1'b1;
        rx_baud <= '0;
        rx_bits <= '0;
        rdy     <= 1'b0;
      end
    end else if (rx_sample) begin
      rx_baud <= '0;
      if (rx_bits == 4'd9) begin
        rx_bits <= '0;
        rx_busy <= 1'b0;
        if (rx_sync) begin
          rx_data <= rx_shft;
          rdy     <= 1'b1;
        end
      end else begin
        if (rx_bits != 4'd0) rx_shft <= {rx_sync, rx_shft[7:1]};
        rx_bits <= rx_bits + 4'd1;
      end
    end else begin
      rx_baud <= rx_baud + CNT_W'(1);
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side command bridge: sends a 16-bit command as two UART bytes (high
// first) and reports single response bytes received from the robot.
module remote_comm
  import knight_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  send_state_t state, nxt;
  logic [15:0] cmd_reg;
  logic        load;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        cmd_snt_nxt;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (resp),
    .rdy     (resp_rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cmd_reg <= '0;
      cmd_snt <= 1'b0;
    end else begin
      state   <= nxt;
      cmd_snt <= cmd_snt_nxt;
      if (load) cmd_reg <= cmd;
    end
  end

  // High byte comes straight from cmd since the latch loads on the same edge.
  always_comb begin
    nxt         = state;
    load        = 1'b0;
    trmt        = 1'b0;
    tx_data     = cmd_reg[15:8];
    cmd_snt_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        tx_data = cmd[15:8];
        if (snd_cmd) begin
          load = 1'b1;
          trmt = 1'b1;
          nxt  = S_HIGH;
        end
      end
      S_HIGH: begin
        tx_data = cmd_reg[7:0];
        if (tx_done) begin
          trmt = 1'b1;
          nxt  = S_LOW;
        end
      end
      S_LOW: begin
        if (tx_done) nxt = S_DONE;
      end
      S_DONE: begin
        cmd_snt_nxt = 1'b1;
        nxt         = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: waveform-level TX model, loopback and directed RX frames.
module tb_remote_comm;
  import knight_pkg::*;

  localparam int unsigned B = 16;
  localparam int SEND_CYC = 20 * B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        loop;
  logic        rx_drv;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] rx_q[$];
  int   rises = 0;
  int   falls = 0;
  logic prev_rdy = 1'b0;

  assign RX = loop ? TX : rx_drv;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always @(negedge clk) begin
    if (resp_rdy === 1'b1 && prev_rdy === 1'b0) begin
      rises++;
      rx_q.push_back(resp);
    end
    if (resp_rdy === 1'b0 && prev_rdy === 1'b1) falls++;
    prev_rdy = resp_rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected TX level k cycles after the accept edge, straight from the 8N1 frame rules.
  function automatic logic exp_tx(input logic [15:0] c, input int k);
    int b;
    int p;
    logic [7:0] by;
    if (k >= SEND_CYC) return 1'b1;
    b  = k / B;
    p  = b % 10;
    by = (b < 10) ? c[15:8] : c[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  // Returns in the cycle where cmd_snt must be high.
  task automatic send(input logic [15:0] c, input bit poke);
    cmd     = c;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    cmd     = 16'($urandom);
    for (int k = 0; k <= SEND_CYC + 1; k++) begin
      check($sformatf("tx_%04h_k%0d", c, k), 32'(TX), 32'(exp_tx(c, k)));
      check($sformatf("cmd_snt_%04h_k%0d", c, k), 32'(cmd_snt), 32'(k == SEND_CYC + 1));
      if (poke && k == 3 * B) begin
        snd_cmd = 1'b1;
        cmd     = 16'hFFFF;
      end else begin
        snd_cmd = 1'b0;
      end
      if (k <= SEND_CYC) step();
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s_tx_%0d", tag, i), 32'(TX), 32'(1'b1));
      check($sformatf("%s_snt_%0d", tag, i), 32'(cmd_snt), 32'(1'b0));
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (B) step();
    end
    rx_drv = 1'b1;
    repeat (B) step();
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_resp;
    logic [7:0]  d;
    logic        stop;
    int          q0;
    int          r0;
    int          f0;

    loop    = 1'b0;
    rx_drv  = 1'b1;
    snd_cmd = 1'b0;
    cmd     = '0;
    rst_n   = 1'b0;
    repeat (3) step();
    check("rst_tx", 32'(TX), 32'(1'b1));
    check("rst_cmd_snt", 32'(cmd_snt), 32'(1'b0));
    check("rst_resp_rdy", 32'(resp_rdy), 32'(1'b0));
    check("rst_resp", 32'(resp), 32'(8'h00));
    rst_n = 1'b1;
    idle(2 * B, "post_rst");

    // Loopback of the two response codes.
    loop = 1'b1;
    q0 = rx_q.size();
    r0 = rises;
    f0 = falls;
    send({POS_ACK, DONE}, 1'b0);
    idle(B, "lb_idle");
    check("lb_count", 32'(rx_q.size() - q0), 32'd2);
    if (rx_q.size() >= q0 + 2) begin
      check("lb_byte0", 32'(rx_q[q0]), 32'(POS_ACK));
      check("lb_byte1", 32'(rx_q[q0+1]), 32'(DONE));
    end
    check("lb_rises", 32'(rises - r0), 32'd2);
    check("lb_falls", 32'(falls - f0), 32'd1);
    check("lb_resp", 32'(resp), 32'(DONE));
    check("lb_rdy", 32'(resp_rdy), 32'(1'b1));

    // Directed 0x7004, busy poke, then a random command, all back-to-back.
    loop = 1'b0;
    send({TOUR, 12'h004}, 1'b0);
    send(16'h7004, 1'b1);
    c = 16'($urandom);
    send(c, 1'b0);
    idle(4 * B, "b2b_idle");

    // Random back-to-back commands received through loopback.
    loop = 1'b1;
    q0 = rx_q.size();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      c = 16'($urandom);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
      send(c, 1'b0);
    end
    idle(2, "rand_lb_idle");
    check("rand_lb_count", 32'(rx_q.size() - q0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (q0 + i < rx_q.size())
        check($sformatf("rand_lb_byte%0d", i), 32'(rx_q[q0+i]), 32'(exp_q[i]));
    end

    // Reset in the middle of a frame.
    cmd     = 16'h1234;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    repeat (5 * B + 3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(TX), 32'(1'b1));
    check("midrst_cmd_snt", 32'(cmd_snt), 32'(1'b0));
    check("midrst_resp_rdy", 32'(resp_rdy), 32'(1'b0));
    check("midrst_resp", 32'(resp), 32'(8'h00));
    repeat (3) step();
    rst_n = 1'b1;
    r0 = rises;
    idle(30 * B, "midrst_after");
    check("midrst_no_rx", 32'(rises - r0), 32'd0);
    check("midrst_rdy_low", 32'(resp_rdy), 32'(1'b0));

    // Framing error leaves response untouched; a good frame follows.
    loop = 1'b0;
    rx_frame(8'h3C, 1'b0);
    check("frm_err_resp", 32'(resp), 32'(8'h00));
    check("frm_err_rdy", 32'(resp_rdy), 32'(1'b0));
    rx_frame(POS_ACK, 1'b1);
    check("frm_ok_resp", 32'(resp), 32'(POS_ACK));
    check("frm_ok_rdy", 32'(resp_rdy), 32'(1'b1));

    // Random frames, some with a bad stop bit.
    model_resp = POS_ACK;
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rx_frame(d, stop);
      if (stop) model_resp = d;
      check($sformatf("rand_rx%0d_resp", i), 32'(resp), 32'(model_resp));
      if (stop) check($sformatf("rand_rx%0d_rdy", i), 32'(resp_rdy), 32'(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
